// File: rtl/four_bit_full_adder.sv
// Registered ripple-carry adder: {c_out, sum} = a + b + c_in, one cycle of latency.
// Define FOUR_BIT_ADDER_FLAGS_EN to add registered signed-overflow (ovf) and zero flags.

module four_bit_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_i,
  output logic s,
  output logic c_o
);
  assign s   = a ^ b ^ c_i;
  assign c_o = (a & b) | (a & c_i) | (b & c_i);
endmodule

module four_bit_full_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             out_valid
`ifdef FOUR_BIT_ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    four_bit_full_adder_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .c_i (carry[i]),
      .s   (sum_comb[i]),
      .c_o (carry[i+1])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset branch sits inside the clocked block, making it synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum       <= '0;
      c_out     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      // Operands are ignored on idle cycles, so X on a/b never reaches the result.
      if (in_valid) begin
        sum   <= sum_comb;
        c_out <= carry[WIDTH];
      end
    end
  end

`ifdef FOUR_BIT_ADDER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else if (in_valid) begin
      ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
      zero <= (sum_comb == '0) && !carry[WIDTH];
    end
  end
`endif

endmodule

// File: tb/tb_four_bit_full_adder.sv
// Randomized and directed bench for four_bit_full_adder against an arithmetic reference model.
// Honors FOUR_BIT_ADDER_FLAGS_EN to also check the ovf/zero flags.

module tb_four_bit_full_adder;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b;
  logic         c_in;
  logic [W-1:0] sum;
  logic         c_out;
  logic         out_valid;
`ifdef FOUR_BIT_ADDER_FLAGS_EN
  logic         ovf, zero;
`endif

  four_bit_full_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sum       (sum),
    .c_out     (c_out),
    .out_valid (out_valid)
`ifdef FOUR_BIT_ADDER_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit armed  = 1'b0;

  // Reference model: plain integer arithmetic on the sampled operands.
  logic [W-1:0] exp_sum;
  logic         exp_c, exp_v, exp_ovf, exp_zero;

  always @(posedge clk) begin
    int t, st;
    t  = int'(a) + int'(b) + int'(c_in);
    st = int'($signed(a)) + int'($signed(b)) + int'(c_in);
    if (!rst_n) begin
      exp_sum <= '0; exp_c <= 1'b0; exp_v <= 1'b0; exp_ovf <= 1'b0; exp_zero <= 1'b0;
    end else begin
      exp_v <= in_valid;
      if (in_valid) begin
        exp_sum  <= W'(t % (1 << W));
        exp_c    <= (t >= (1 << W));
        exp_ovf  <= (st > (1 << (W-1)) - 1) || (st < -(1 << (W-1)));
        exp_zero <= (t == 0);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("model_sum", 32'(sum), 32'(exp_sum));
      check("model_c_out", 32'(c_out), 32'(exp_c));
      check("model_out_valid", 32'(out_valid), 32'(exp_v));
`ifdef FOUR_BIT_ADDER_FLAGS_EN
      check("model_ovf", 32'(ovf), 32'(exp_ovf));
      check("model_zero", 32'(zero), 32'(exp_zero));
`endif
    end
  end

  task automatic step(input logic r, input logic v, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic cc);
    rst_n = r; in_valid = v; a = aa; b = bb; c_in = cc;
    n_vec++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF; c_in = 1'b0;

    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 4'hF, 4'hF, 1'b0);
      armed = 1'b1;
      check("reset_sum", 32'(sum), 32'h0);
      check("reset_c_out", 32'(c_out), 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'h0);
    end

    step(1'b1, 1'b1, 4'b0011, 4'b0101, 1'b1);
    check("lit_3p5p1", 32'({c_out, sum}), 32'h09);
    check("lit_3p5p1_valid", 32'(out_valid), 32'h1);
    step(1'b1, 1'b1, 4'hF, 4'h0, 1'b1);
    check("lit_Fp0p1", 32'({c_out, sum}), 32'h10);
    step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
    check("lit_FpFp1", 32'({c_out, sum}), 32'h1F);

    step(1'b1, 1'b1, 4'h7, 4'h1, 1'b0);
    check("hold_first", 32'({c_out, sum}), 32'h08);
    check("hold_first_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, W'($urandom), W'($urandom), 1'($urandom));
      check("hold_value", 32'({c_out, sum}), 32'h08);
      check("hold_valid_low", 32'(out_valid), 32'h0);
    end

    step(1'b0, 1'b1, 4'h9, 4'h9, 1'b0);
    check("midreset_valid", 32'(out_valid), 32'h0);
    check("midreset_sum", 32'(sum), 32'h0);

    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < 16; j++)
          step(1'b1, 1'b1, W'(i), W'(j), 1'(c));

    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 49) != 0), 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));

`ifdef FOUR_BIT_ADDER_FLAGS_EN
    step(1'b1, 1'b1, 4'h7, 4'h1, 1'b0);
    check("flag_7p1_ovf", 32'(ovf), 32'h1);
    check("flag_7p1_zero", 32'(zero), 32'h0);
    step(1'b1, 1'b1, 4'h8, 4'h8, 1'b0);
    check("flag_8p8_sum", 32'({c_out, sum}), 32'h10);
    check("flag_8p8_ovf", 32'(ovf), 32'h1);
    check("flag_8p8_zero", 32'(zero), 32'h0);
    step(1'b1, 1'b1, 4'h0, 4'h0, 1'b0);
    check("flag_0p0_zero", 32'(zero), 32'h1);
    check("flag_0p0_ovf", 32'(ovf), 32'h0);
`endif

    step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
